// File: rtl/neuron_sequencer_pkg.sv
// Shared definitions for the neuron sequencer: FSM encoding, default sizes
// and a constant-evaluable ceil(log2) helper used to size the pair counter.
package neuron_sequencer_pkg;

  localparam int M_DEF        = 18;
  localparam int N_INPUTS_DEF = 16;
  localparam int MULT_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Pair stream and result handshake between the sequencer and its neighbours.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds valid and its data
// stable until that edge; ready may be asserted or dropped freely and never
// depends combinationally on valid.
interface neuron_sequencer_if #(
  parameter int M = 18
);

  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_in;
  logic [7:0]   s_weight;
  logic [M-1:0] result;
  logic         result_valid;
  logic         result_ready;

  // Upstream pair source and downstream result consumer.
  modport master (
    output s_valid, s_in, s_weight, result_ready,
    input  s_ready, result, result_valid
  );

  // The sequencer itself.
  modport slave (
    input  s_valid, s_in, s_weight, result_ready,
    output s_ready, result, result_valid
  );

endinterface

// File: rtl/neuron_valid_pipe.sv
// Bit shift register tracking which cycles carry a loaded pair through the
// datapath multiplier; the tap at depth MULT_LAT drives the accumulator enable.
module neuron_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             din,
  output logic [DEPTH-1:0] pipe
);

  // Shift every cycle; clear drops all in-flight markers at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else if (clear) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Control stage in front of the neuron datapath: clears the accumulator,
// streams N_INPUTS (input, weight) pairs, waits for the multiplier pipeline
// to empty, then holds the activated output until the consumer takes it.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  neuron_sequencer_if.slave     bus,
  output logic [7:0]            dp_in,
  output logic [7:0]            dp_weight,
  output logic                  input_register,
  output logic                  acumulator_register_en,
  output logic                  acc_clr,
  input  logic [M-1:0]          dp_out,
  output state_t                dbg_state
);

  localparam int            CW   = clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [MULT_LAT:0] pipe;
  logic            s_ready_c;
  logic            hs;
  logic [M-1:0]    result_q;
  logic            result_valid_q;

  assign hs                     = s_ready_c & bus.s_valid;
  assign bus.s_ready            = s_ready_c;
  assign bus.result             = result_q;
  assign bus.result_valid       = result_valid_q;
  assign input_register         = hs;
  assign acumulator_register_en = pipe[MULT_LAT] & ~abort;
  assign busy                   = (state != ST_IDLE);
  assign dp_in                  = bus.s_in;
  assign dp_weight              = bus.s_weight;
  assign dbg_state              = state;

  neuron_valid_pipe #(
    .DEPTH (MULT_LAT + 1)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .clear (abort),
    .din   (hs),
    .pipe  (pipe)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded controls; abort overrides everything.
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    acc_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = ST_FEED;
      end
      ST_FEED: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && (count == LAST)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave only once no pair is left in flight, so the last
        // accumulation has landed before the capture cycle.
        if (pipe == '0) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.result_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      s_ready_c = 1'b0;
    end
  end

  // Pair counter; a handshake is only possible while count < N_INPUTS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (abort || (state == ST_CLEAR)) begin
      count <= '0;
    end else if (hs) begin
      count <= count + 1'b1;
    end
  end

  // Result holding register; abort drops valid but keeps the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (abort) begin
      result_valid_q <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      result_q       <= dp_out;
      result_valid_q <= 1'b1;
    end else if ((state == ST_DONE) && bus.result_ready) begin
      result_valid_q <= 1'b0;
    end
  end

endmodule
